// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data-stage and memory-port signals for mem_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
   parameter int AW = 64,
   parameter int DW = 64
);
   logic          if_req_i;
   logic [AW-1:0] if_addr_i;
   logic          if_cancel_i;
   logic          if_ack_o;
   logic [DW-1:0] if_rdata_o;
   logic          if_err_o;

   logic          dm_req_i;
   logic          dm_we_i;
   logic [AW-1:0] dm_addr_i;
   logic [DW-1:0] dm_wdata_i;
   logic          dm_ack_o;
   logic [DW-1:0] dm_rdata_o;
   logic          dm_err_o;

   logic          mem_req_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic          mem_ack_i;
   logic [DW-1:0] mem_rdata_i;
   logic          mem_err_i;

   modport slave (
      input  if_req_i, if_addr_i, if_cancel_i,
      output if_ack_o, if_rdata_o, if_err_o,
      input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
      output dm_ack_o, dm_rdata_o, dm_err_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_ack_i, mem_rdata_i, mem_err_i
   );

   modport master (
      output if_req_i, if_addr_i, if_cancel_i,
      input  if_ack_o, if_rdata_o, if_err_o,
      output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
      input  dm_ack_o, dm_rdata_o, dm_err_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_ack_i, mem_rdata_i, mem_err_i
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, data stage) arbiter onto a single-outstanding memory port.
// Define MEM_ARBITER_TIMEOUT_EN to add an 8-bit watchdog that aborts a stalled access.
module mem_arbiter #(
   parameter int AW      = 64,
   parameter int DW      = 64,
   parameter int TIMEOUT = 255
) (
   input  logic          clk_i,
   input  logic          rst_i,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_e;

   state_e        state_q, state_d;
   logic          cancel_q, cancel_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          if_ack_q, if_ack_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic          if_err_q, if_err_d;
   logic          dm_ack_q, dm_ack_d;
   logic [DW-1:0] dm_rdata_q, dm_rdata_d;
   logic          dm_err_q, dm_err_d;

   logic          fin;
   logic [DW-1:0] fin_rdata;
   logic          fin_err;

`ifdef MEM_ARBITER_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] wdog_q, wdog_d;
`endif

   always_comb begin
      state_d     = state_q;
      cancel_d    = cancel_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_ack_d    = 1'b0;
      if_rdata_d  = '0;
      if_err_d    = 1'b0;
      dm_ack_d    = 1'b0;
      dm_rdata_d  = '0;
      dm_err_d    = 1'b0;
      fin         = 1'b0;
      fin_rdata   = '0;
      fin_err     = 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      wdog_d      = wdog_q;
`endif
      case (state_q)
         IDLE: begin
            cancel_d = 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
            wdog_d   = '0;
`endif
            // A requester being acked this cycle is still holding its old request.
            if (bus.dm_req_i && !dm_ack_q) begin
               state_d     = BUSY_DM;
               mem_req_d   = 1'b1;
               mem_we_d    = bus.dm_we_i;
               mem_addr_d  = bus.dm_addr_i;
               mem_wdata_d = bus.dm_wdata_i;
            end else if (bus.if_req_i && !bus.if_cancel_i && !if_ack_q) begin
               state_d     = BUSY_IF;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = bus.if_addr_i;
               mem_wdata_d = '0;
            end
         end
         BUSY_IF, BUSY_DM: begin
            if (state_q == BUSY_IF && bus.if_cancel_i) cancel_d = 1'b1;
            if (bus.mem_ack_i) begin
               fin       = 1'b1;
               fin_rdata = bus.mem_rdata_i;
               fin_err   = bus.mem_err_i;
            end
`ifdef MEM_ARBITER_TIMEOUT_EN
            else if (wdog_q == TO_LAST) begin
               fin     = 1'b1;
               fin_err = 1'b1;
            end else begin
               wdog_d = wdog_q + 8'd1;
            end
`endif
            if (fin) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               cancel_d  = 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
               wdog_d    = '0;
`endif
               if (state_q == BUSY_DM) begin
                  dm_ack_d   = 1'b1;
                  dm_rdata_d = fin_rdata;
                  dm_err_d   = fin_err;
               end else if (!(cancel_q || bus.if_cancel_i)) begin
                  // a flushed fetch still drains the port but is never returned
                  if_ack_d   = 1'b1;
                  if_rdata_d = fin_rdata;
                  if_err_d   = fin_err;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cancel_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         if_rdata_q  <= '0;
         if_err_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         dm_rdata_q  <= '0;
         dm_err_q    <= 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
         wdog_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cancel_q    <= cancel_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_ack_q    <= if_ack_d;
         if_rdata_q  <= if_rdata_d;
         if_err_q    <= if_err_d;
         dm_ack_q    <= dm_ack_d;
         dm_rdata_q  <= dm_rdata_d;
         dm_err_q    <= dm_err_d;
`ifdef MEM_ARBITER_TIMEOUT_EN
         wdog_q      <= wdog_d;
`endif
      end
   end

   assign bus.mem_req_o   = mem_req_q;
   assign bus.mem_we_o    = mem_we_q;
   assign bus.mem_addr_o  = mem_addr_q;
   assign bus.mem_wdata_o = mem_wdata_q;
   assign bus.if_ack_o    = if_ack_q;
   assign bus.if_rdata_o  = if_rdata_q;
   assign bus.if_err_o    = if_err_q;
   assign bus.dm_ack_o    = dm_ack_q;
   assign bus.dm_rdata_o  = dm_rdata_q;
   assign bus.dm_err_o    = dm_err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: AW, 64, address width; DW, 64, data width; TIMEOUT, 255, watchdog limit in cycles (1..255).
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  asynchronous reset, active-high.
REQ-004 if_req_i  in  1  fetch read request; held until if_ack_o or cancel.
REQ-005 if_addr_i  in  AW  fetch address.
REQ-006 if_cancel_i  in  1  fetch flush (mispredict/ret redirect).
REQ-007 if_ack_o  out  1  one-cycle fetch completion pulse.
REQ-008 if_rdata_o  out  DW  fetch read data, valid with if_ack_o.
REQ-009 if_err_o  out  1  fetch error, valid with if_ack_o.
REQ-010 dm_req_i  in  1  memory-stage request; held until dm_ack_o.
REQ-011 dm_we_i  in  1  1 = write, 0 = read.
REQ-012 dm_addr_i  in  AW  data address.
REQ-013 dm_wdata_i  in  DW  write data.
REQ-014 dm_ack_o  out  1  one-cycle data completion pulse.
REQ-015 dm_rdata_o  out  DW  read data, valid with dm_ack_o.
REQ-016 dm_err_o  out  1  data error, valid with dm_ack_o.
REQ-017 mem_req_o  out  1  memory-port request, held until mem_ack_i.
REQ-018 mem_we_o / mem_addr_o / mem_wdata_o  out  1/AW/DW  registered command, stable while mem_req_o=1.
REQ-019 mem_ack_i  in  1  memory completion; mem_rdata_i (DW) and mem_err_i (1) valid same cycle.

Function
REQ-020 FSM states SHALL be IDLE, BUSY_IF, BUSY_DM; exactly one transaction outstanding on the memory port.
REQ-021 In IDLE, dm_req_i=1 SHALL move to BUSY_DM; else if_req_i=1 and if_cancel_i=0 SHALL move to BUSY_IF; else stay IDLE.
REQ-022 Simultaneous if_req_i and dm_req_i in IDLE SHALL grant dm (fixed priority; memory stage is older).
REQ-023 On grant edge, command fields SHALL be captured and mem_req_o=1 from the next cycle (one-cycle issue latency).
REQ-024 mem_req_o SHALL stay 1 with unchanged command until the cycle mem_ack_i=1; mem_ack_i outside BUSY_* SHALL be ignored.
REQ-025 mem_ack_i in BUSY_x SHALL, at that edge, deassert mem_req_o, return to IDLE, and pulse x_ack_o for exactly the next cycle with registered mem_rdata_i/mem_err_i.
REQ-026 Fetch writes never issue: mem_we_o=0 for BUSY_IF.
REQ-027 In the cycle x_ack_o=1, that requester's req_i SHALL be ignored (no re-issue of a completed request); the other requester may be granted that cycle.
REQ-028 if_cancel_i=1 while BUSY_IF SHALL set a cancel flag; transaction still completes on the memory port, if_ack_o suppressed, flag cleared on return to IDLE.
REQ-029 if_cancel_i=1 in IDLE SHALL block fetch grant that cycle only.
REQ-030 x_rdata_o SHALL be 0 when x_ack_o=0; x_err_o SHALL be 0 when x_ack_o=0.
REQ-031 Back-to-back: IDLE with pending request after ack SHALL grant without extra idle cycle, giving 3-cycle minimum request-to-request period with single-cycle memory.

Reset
REQ-032 rst_i=1 SHALL immediately force IDLE, clear cancel flag and watchdog, and drive all outputs 0, including mid-transaction.
REQ-033 A mem_ack_i arriving after reset SHALL be ignored; requesters re-issue.

Configuration
REQ-034 Macro MEM_ARBITER_TIMEOUT_EN SHALL compile in an 8-bit watchdog counting cycles in BUSY_* since mem_req_o rose.
REQ-035 With macro: count reaching TIMEOUT without mem_ack_i SHALL deassert mem_req_o, return IDLE, and pulse owner ack with err=1, rdata=0 (cancel still suppresses if_ack_o); ack on the same cycle as expiry wins as normal completion.
REQ-036 Without macro: no counter logic; BUSY_* waits for mem_ack_i indefinitely.

Verification
REQ-037 IDLE, dm_req read addr 0x100, mem_ack_i 2 cycles after mem_req_o with rdata 0xDEAD -> mem_req_o 2 cycles, dm_ack_o 1 cycle with 0xDEAD, err 0.
REQ-038 if_req and dm_req (write 0x200, data 0x55) same cycle -> dm served first with mem_we_o=1, fetch issued cycle after dm_ack_o.
REQ-039 BUSY_IF, if_cancel_i pulse, then mem_ack_i -> no if_ack_o, IDLE next, pending dm_req granted.
REQ-040 rst_i asserted while BUSY_DM with mem_req_o=1 -> all outputs 0 same cycle, later mem_ack_i ignored.
REQ-041 Macro on, TIMEOUT=4, no mem_ack_i -> mem_req_o drops after 4 cycles, dm_ack_o=1, dm_err_o=1, dm_rdata_o=0; macro off -> mem_req_o held.
